// File: rtl/dma_ram_pkg.sv
// Shared definitions for the segmented DMA RAM.
//   - default segment geometry used by dma_seg_ram
//   - byte-enable merge helper used by each segment's write port
package dma_ram_pkg;

  localparam int SEG_COUNT_DEF      = 4;
  localparam int SEG_DATA_WIDTH_DEF = 128;
  localparam int SEG_ADDR_WIDTH_DEF = 12;
  localparam int SEG_BE_WIDTH_DEF   = SEG_DATA_WIDTH_DEF / 8;
  localparam int PIPELINE_DEF       = 2;
  localparam int BYTE_WIDTH         = 8;

  // Returns the byte that ends up in the array: the new byte when its
  // enable is set, otherwise the byte already stored.
  function automatic logic [BYTE_WIDTH-1:0] be_merge_byte(
    input logic [BYTE_WIDTH-1:0] old_byte,
    input logic [BYTE_WIDTH-1:0] new_byte,
    input logic                  en
  );
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dma_seg_ram_segment.sv
// One RAM segment: storage array, byte-enabled write port with a done
// strobe, and a read port feeding a back-pressurable register pipeline.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   wr_cmd_be/addr/data/valid/ready     write command
//   wr_done                             one-cycle strobe after each write
//   rd_cmd_addr/valid/ready             read command
//   rd_resp_data/valid/ready            read response (last pipeline stage)
module dma_seg_ram_segment
  import dma_ram_pkg::*;
#(
  parameter int DATA_WIDTH = SEG_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = SEG_ADDR_WIDTH_DEF,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int PIPELINE   = PIPELINE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BE_WIDTH-1:0]   wr_cmd_be,
  input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0] wr_cmd_data,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  output logic                  wr_done,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_fire;
  logic                  rd_fire;
  logic [PIPELINE-1:0]   st_valid;
  logic [DATA_WIDTH-1:0] st_data [PIPELINE];
  logic [PIPELINE-1:0]   st_adv;

  // Write port never stalls once out of reset.
  assign wr_cmd_ready = rst_n;
  assign wr_fire      = wr_cmd_valid & wr_cmd_ready;

  // Array is intentionally not reset. Non-blocking update here together with
  // the stage-0 load below gives read-first behaviour on address collisions.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < BE_WIDTH; j++) begin
        mem[wr_cmd_addr][j*BYTE_WIDTH +: BYTE_WIDTH] <=
          be_merge_byte(mem[wr_cmd_addr][j*BYTE_WIDTH +: BYTE_WIDTH],
                        wr_cmd_data[j*BYTE_WIDTH +: BYTE_WIDTH],
                        wr_cmd_be[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done <= 1'b0;
    end else begin
      wr_done <= wr_fire;
    end
  end

  // A full stage can move forward when the output is being consumed or any
  // stage ahead of it holds a bubble: bubbles collapse as the chain shifts.
  // Written this way so no advance bit depends on another advance bit.
  always_comb begin
    logic room;
    room   = 1'b0;
    st_adv = '0;
    for (int k = 0; k < PIPELINE; k++) begin
      room = rd_resp_ready;
      for (int j = k + 1; j < PIPELINE; j++) begin
        if (!st_valid[j]) begin
          room = 1'b1;
        end
      end
      st_adv[k] = st_valid[k] & room;
    end
  end

  assign rd_cmd_ready = rst_n & (~st_valid[0] | st_adv[0]);
  assign rd_fire      = rd_cmd_valid & rd_cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int k = 0; k < PIPELINE; k++) begin
        st_data[k] <= '0;
      end
    end else begin
      if (rd_fire) begin
        st_valid[0] <= 1'b1;
        st_data[0]  <= mem[rd_cmd_addr];
      end else if (st_adv[0]) begin
        st_valid[0] <= 1'b0;
      end
      for (int k = 1; k < PIPELINE; k++) begin
        if (st_adv[k-1]) begin
          st_valid[k] <= 1'b1;
          st_data[k]  <= st_data[k-1];
        end else if (st_adv[k]) begin
          st_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign rd_resp_valid = st_valid[PIPELINE-1];
  assign rd_resp_data  = st_data[PIPELINE-1];

endmodule

// File: rtl/dma_seg_ram.sv
// Segmented simple-dual-port packet buffer RAM. Each segment has its own
// write port (command + done strobe) and read port (command + pipelined,
// back-pressurable response). Segment i uses slice i of every bus.
// Ports:
//   clk, rst_n                                   clock, async active-low reset
//   ram_wr_cmd_be/addr/data/valid/ready          per-segment write commands
//   ram_wr_done                                  per-segment write-complete
//   ram_rd_cmd_addr/valid/ready                  per-segment read commands
//   ram_rd_resp_data/valid/ready                 per-segment read responses
module dma_seg_ram
  import dma_ram_pkg::*;
#(
  parameter int SEG_COUNT      = SEG_COUNT_DEF,
  parameter int SEG_DATA_WIDTH = SEG_DATA_WIDTH_DEF,
  parameter int SEG_ADDR_WIDTH = SEG_ADDR_WIDTH_DEF,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int PIPELINE       = PIPELINE_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   ram_wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                ram_wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                ram_wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                ram_wr_done,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                ram_rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                ram_rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
  output logic [SEG_COUNT-1:0]                ram_rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                ram_rd_resp_ready
);

  for (genvar i = 0; i < SEG_COUNT; i++) begin : g_seg
    dma_seg_ram_segment #(
      .DATA_WIDTH (SEG_DATA_WIDTH),
      .ADDR_WIDTH (SEG_ADDR_WIDTH),
      .BE_WIDTH   (SEG_BE_WIDTH),
      .PIPELINE   (PIPELINE)
    ) u_seg (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_cmd_be     (ram_wr_cmd_be[i*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
      .wr_cmd_addr   (ram_wr_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .wr_cmd_data   (ram_wr_cmd_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .wr_cmd_valid  (ram_wr_cmd_valid[i]),
      .wr_cmd_ready  (ram_wr_cmd_ready[i]),
      .wr_done       (ram_wr_done[i]),
      .rd_cmd_addr   (ram_rd_cmd_addr[i*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
      .rd_cmd_valid  (ram_rd_cmd_valid[i]),
      .rd_cmd_ready  (ram_rd_cmd_ready[i]),
      .rd_resp_data  (ram_rd_resp_data[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
      .rd_resp_valid (ram_rd_resp_valid[i]),
      .rd_resp_ready (ram_rd_resp_ready[i])
    );
  end

endmodule

// File: tb/tb_dma_seg_ram.sv
module tb_dma_seg_ram;

  localparam int SC = 4;
  localparam int DW = 128;
  localparam int AW = 12;
  localparam int BW = DW / 8;
  localparam int PL = 2;

  typedef logic [DW-1:0] data_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SC*BW-1:0]  ram_wr_cmd_be = '0;
  logic [SC*AW-1:0]  ram_wr_cmd_addr = '0;
  logic [SC*DW-1:0]  ram_wr_cmd_data = '0;
  logic [SC-1:0]     ram_wr_cmd_valid = '0;
  logic [SC-1:0]     ram_wr_cmd_ready;
  logic [SC-1:0]     ram_wr_done;
  logic [SC*AW-1:0]  ram_rd_cmd_addr = '0;
  logic [SC-1:0]     ram_rd_cmd_valid = '0;
  logic [SC-1:0]     ram_rd_cmd_ready;
  logic [SC*DW-1:0]  ram_rd_resp_data;
  logic [SC-1:0]     ram_rd_resp_valid;
  logic [SC-1:0]     ram_rd_resp_ready = '0;

  always #5 clk = ~clk;

  dma_seg_ram #(
    .SEG_COUNT      (SC),
    .SEG_DATA_WIDTH (DW),
    .SEG_ADDR_WIDTH (AW),
    .SEG_BE_WIDTH   (BW),
    .PIPELINE       (PL)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ram_wr_cmd_be     (ram_wr_cmd_be),
    .ram_wr_cmd_addr   (ram_wr_cmd_addr),
    .ram_wr_cmd_data   (ram_wr_cmd_data),
    .ram_wr_cmd_valid  (ram_wr_cmd_valid),
    .ram_wr_cmd_ready  (ram_wr_cmd_ready),
    .ram_wr_done       (ram_wr_done),
    .ram_rd_cmd_addr   (ram_rd_cmd_addr),
    .ram_rd_cmd_valid  (ram_rd_cmd_valid),
    .ram_rd_cmd_ready  (ram_rd_cmd_ready),
    .ram_rd_resp_data  (ram_rd_resp_data),
    .ram_rd_resp_valid (ram_rd_resp_valid),
    .ram_rd_resp_ready (ram_rd_resp_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input data_t obs, input data_t exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: word store keyed by segment/address, plus one queue of
  // expected responses per segment.
  data_t mdl_mem [int];
  data_t exp_q [SC][$];

  function automatic data_t mdl_read(input int s, input int a);
    int k = s * (2 ** AW) + a;
    if (mdl_mem.exists(k)) return mdl_mem[k];
    return 'x;
  endfunction

  function automatic void mdl_write(input int s, input int a,
                                    input logic [BW-1:0] be, input data_t d);
    int k = s * (2 ** AW) + a;
    data_t v = mdl_mem.exists(k) ? mdl_mem[k] : '0;
    for (int j = 0; j < BW; j++) begin
      if (be[j]) v[j*8 +: 8] = d[j*8 +: 8];
    end
    mdl_mem[k] = v;
  endfunction

  // Monitor at the falling edge: inputs and combinational readies are stable
  // and describe what happens at the next rising edge.
  bit          mon_en = 1'b0;
  logic [SC-1:0] exp_done = '0;
  logic [SC-1:0] prev_stall = '0;
  data_t       prev_data [SC];

  always @(negedge clk) begin
    logic [SC-1:0] done_next;
    done_next = '0;
    if (!rst_n) begin
      exp_done   = '0;
      prev_stall = '0;
      for (int s = 0; s < SC; s++) exp_q[s].delete();
    end else if (mon_en) begin
      for (int s = 0; s < SC; s++) begin
        data_t rdat;
        rdat = ram_rd_resp_data[s*DW +: DW];
        check_val($sformatf("wr_done_s%0d", s), data_t'(ram_wr_done[s]), data_t'(exp_done[s]));
        if (prev_stall[s]) begin
          check_val($sformatf("hold_valid_s%0d", s), data_t'(ram_rd_resp_valid[s]), data_t'(1));
          check_val($sformatf("hold_data_s%0d", s), rdat, prev_data[s]);
        end
        if (ram_rd_resp_valid[s] && ram_rd_resp_ready[s]) begin
          check_val($sformatf("resp_expected_s%0d", s),
                    data_t'(exp_q[s].size() > 0), data_t'(1));
          if (exp_q[s].size() > 0) begin
            check_val($sformatf("resp_data_s%0d", s), rdat, exp_q[s].pop_front());
          end
        end
        // Read sampled before the same-edge write is applied: read-first.
        if (ram_rd_cmd_valid[s] && ram_rd_cmd_ready[s]) begin
          exp_q[s].push_back(mdl_read(s, int'(ram_rd_cmd_addr[s*AW +: AW])));
        end
        if (ram_wr_cmd_valid[s] && ram_wr_cmd_ready[s]) begin
          mdl_write(s, int'(ram_wr_cmd_addr[s*AW +: AW]), ram_wr_cmd_be[s*BW +: BW],
                    ram_wr_cmd_data[s*DW +: DW]);
          done_next[s] = 1'b1;
        end
        prev_data[s] = rdat;
      end
      exp_done   = done_next;
      prev_stall = ram_rd_resp_valid & ~ram_rd_resp_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ram_wr_cmd_valid = '0;
    ram_rd_cmd_valid = '0;
  endtask

  task automatic set_wr(input int s, input int a, input logic [BW-1:0] be, input data_t d);
    ram_wr_cmd_be[s*BW +: BW]   = be;
    ram_wr_cmd_addr[s*AW +: AW] = AW'(a);
    ram_wr_cmd_data[s*DW +: DW] = d;
    ram_wr_cmd_valid[s]         = 1'b1;
  endtask

  task automatic set_rd(input int s, input int a);
    ram_rd_cmd_addr[s*AW +: AW] = AW'(a);
    ram_rd_cmd_valid[s]         = 1'b1;
  endtask

  function automatic data_t rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic data_t seg_data(input int s);
    return ram_rd_resp_data[s*DW +: DW];
  endfunction

  initial begin
    int a;
    bit seen_block;
    bit drained;
    data_t v_new;

    // Reset
    for (int c = 0; c < 5; c++) tick();
    check_val("rst_wr_ready", data_t'(ram_wr_cmd_ready), '0);
    check_val("rst_rd_ready", data_t'(ram_rd_cmd_ready), '0);
    check_val("rst_resp_valid", data_t'(ram_rd_resp_valid), '0);
    check_val("rst_wr_done", data_t'(ram_wr_done), '0);
    check_val("rst_resp_data", data_t'(ram_rd_resp_data[DW-1:0]), '0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_wr_ready", data_t'(ram_wr_cmd_ready), data_t'(4'hF));
    check_val("post_rst_rd_ready", data_t'(ram_rd_cmd_ready), data_t'(4'hF));
    tick();
    mon_en = 1'b1;

    // Fill addresses 0..15 of every segment so later reads are defined.
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SC; s++) set_wr(s, i, '1, rnd_data());
      tick();
    end
    idle();
    ram_rd_resp_ready = '1;
    tick();

    // Write/read round trip on seg0
    set_wr(0, 'h010, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    tick();
    idle();
    check_val("rt_wr_done", data_t'(ram_wr_done[0]), data_t'(1));
    tick();
    check_val("rt_wr_done_once", data_t'(ram_wr_done[0]), data_t'(0));
    set_rd(0, 'h010);
    check_val("rt_rd_ready", data_t'(ram_rd_cmd_ready[0]), data_t'(1));
    tick();
    idle();
    check_val("rt_lat1_valid", data_t'(ram_rd_resp_valid[0]), data_t'(0));
    tick();
    check_val("rt_lat2_valid", data_t'(ram_rd_resp_valid[0]), data_t'(1));
    check_val("rt_data", seg_data(0), 128'h00112233_44556677_8899AABB_CCDDEEFF);
    tick();

    // Partial byte enable on seg2
    set_wr(2, 'h020, '1, {16{8'hAA}});
    tick();
    set_wr(2, 'h020, 16'h000F, {16{8'h55}});
    tick();
    idle();
    set_rd(2, 'h020);
    tick();
    idle();
    tick();
    check_val("pbe_valid", data_t'(ram_rd_resp_valid[2]), data_t'(1));
    check_val("pbe_data", seg_data(2), 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_55555555);
    tick();

    // Backpressure on seg1
    ram_rd_resp_ready[1] = 1'b0;
    a = 0;
    seen_block = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_rd(1, a);
      if (!ram_rd_cmd_ready[1] && !seen_block) begin
        check_val("bp_accepts", data_t'(a), data_t'(PL));
        seen_block = 1'b1;
      end
      if (ram_rd_cmd_ready[1]) a++;
      tick();
    end
    check_val("bp_blocked", data_t'(seen_block), data_t'(1));
    check_val("bp_stalled_valid", data_t'(ram_rd_resp_valid[1]), data_t'(1));
    ram_rd_resp_ready[1] = 1'b1;
    for (int c = 0; c < 20 && a < 4; c++) begin
      set_rd(1, a);
      if (ram_rd_cmd_ready[1]) a++;
      tick();
    end
    idle();
    check_val("bp_all_issued", data_t'(a), data_t'(4));
    for (int c = 0; c < 6; c++) tick();
    check_val("bp_drained", data_t'(exp_q[1].size()), '0);

    // Segment independence
    set_wr(3, 5, '1, {16{8'h77}});
    tick();
    v_new = rnd_data();
    set_wr(0, 5, '1, v_new);
    ram_wr_cmd_valid[3] = 1'b0;
    set_rd(3, 5);
    tick();
    idle();
    tick();
    check_val("ind_seg3_valid", data_t'(ram_rd_resp_valid[3]), data_t'(1));
    check_val("ind_seg3_data", seg_data(3), {16{8'h77}});
    set_rd(0, 5);
    tick();
    idle();
    tick();
    check_val("ind_seg0_data", seg_data(0), v_new);
    tick();

    // Read-during-write collision on seg1
    set_wr(1, 'h100, '1, data_t'(1));
    tick();
    set_wr(1, 'h100, '1, data_t'(2));
    set_rd(1, 'h100);
    tick();
    idle();
    tick();
    check_val("col_old", seg_data(1), data_t'(1));
    set_rd(1, 'h100);
    tick();
    idle();
    tick();
    check_val("col_new", seg_data(1), data_t'(2));
    tick();

    // Randomized traffic over the initialised address range
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < SC; s++) begin
        ram_wr_cmd_valid[s] = 1'b0;
        ram_rd_cmd_valid[s] = 1'b0;
        if ($urandom_range(1, 0) == 1)
          set_wr(s, $urandom_range(15, 0), BW'($urandom), rnd_data());
        if ($urandom_range(1, 0) == 1)
          set_rd(s, $urandom_range(15, 0));
        ram_rd_resp_ready[s] = ($urandom_range(9, 0) < 7);
      end
      tick();
    end
    idle();
    ram_rd_resp_ready = '1;
    drained = 1'b0;
    for (int c = 0; c < 50 && !drained; c++) begin
      tick();
      drained = 1'b1;
      for (int s = 0; s < SC; s++) if (exp_q[s].size() != 0) drained = 1'b0;
    end
    for (int s = 0; s < SC; s++)
      check_val($sformatf("rand_drain_s%0d", s), data_t'(exp_q[s].size()), '0);

    // Reset with reads in flight discards them
    ram_rd_resp_ready[0] = 1'b0;
    set_rd(0, 3);
    tick();
    set_rd(0, 4);
    tick();
    idle();
    check_val("mid_pre_valid", data_t'(ram_rd_resp_valid[0]), data_t'(1));
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", data_t'(ram_rd_resp_valid), '0);
    check_val("mid_rst_rd_ready", data_t'(ram_rd_cmd_ready), '0);
    tick();
    tick();
    rst_n = 1'b1;
    ram_rd_resp_ready = '1;
    tick();
    check_val("mid_post_valid", data_t'(ram_rd_resp_valid), '0);
    // Contents survive reset
    set_rd(2, 'h020);
    tick();
    idle();
    tick();
    check_val("mid_mem_kept", seg_data(2), 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_55555555);
    for (int c = 0; c < 4; c++) tick();
    for (int s = 0; s < SC; s++)
      check_val($sformatf("final_drain_s%0d", s), data_t'(exp_q[s].size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_seg_ram.md
Name: dma_seg_ram

Overview:
- Segmented simple-dual-port RAM that consumes the segmented write-command stream produced by the DMA client AXI-stream sink.
- Each segment has one independent write port (command + done strobe) and one independent read port (command + response) with a registered, back-pressurable output pipeline.
- Sits between DMA clients (write side) and DMA interface/read-out engines (read side), acting as packet buffer RAM.

Parameters:
- SEG_COUNT, 4, number of independent RAM segments
- SEG_DATA_WIDTH, 128, data bits per segment
- SEG_ADDR_WIDTH, 12, word address bits per segment (depth 2**SEG_ADDR_WIDTH)
- SEG_BE_WIDTH, SEG_DATA_WIDTH/8, byte enables per segment
- PIPELINE, 2, read latency in cycles, minimum 1

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ram_wr_cmd_be  input  SEG_COUNT*SEG_BE_WIDTH  per-segment byte enables
- ram_wr_cmd_addr  input  SEG_COUNT*SEG_ADDR_WIDTH  per-segment word address
- ram_wr_cmd_data  input  SEG_COUNT*SEG_DATA_WIDTH  per-segment write data
- ram_wr_cmd_valid  input  SEG_COUNT  per-segment write command valid
- ram_wr_cmd_ready  output  SEG_COUNT  per-segment write command ready
- ram_wr_done  output  SEG_COUNT  per-segment write-complete strobe
- ram_rd_cmd_addr  input  SEG_COUNT*SEG_ADDR_WIDTH  per-segment read address
- ram_rd_cmd_valid  input  SEG_COUNT  per-segment read command valid
- ram_rd_cmd_ready  output  SEG_COUNT  per-segment read command ready
- ram_rd_resp_data  output  SEG_COUNT*SEG_DATA_WIDTH  per-segment read data
- ram_rd_resp_valid  output  SEG_COUNT  per-segment response valid
- ram_rd_resp_ready  input  SEG_COUNT  per-segment response ready

Behaviour:
- Single clock domain: clk. Reset: rst_n, asynchronous assert, active low.
- Reset values:
  - ram_wr_cmd_ready = 0, ram_rd_cmd_ready = 0 while rst_n is low.
  - ram_wr_done = 0, ram_rd_resp_valid = 0, all pipeline valid bits = 0, ram_rd_resp_data = 0.
  - Memory contents are not reset.
- Segments are fully independent. Segment i uses bit slice i of every bus.
- Write path:
  - ram_wr_cmd_ready[i] = 1 whenever out of reset.
  - On valid&ready, each byte j with be[j]=1 is written at the rising edge; bytes with be[j]=0 are unchanged.
  - ram_wr_done[i] pulses high for exactly one cycle, the cycle after acceptance.
  - A command with be=0 still produces a done pulse.
  - Back-to-back commands give one done per cycle.
- Read path:
  - PIPELINE register stages per segment, each holding {valid, data}.
  - A command is accepted on ram_rd_cmd_valid & ram_rd_cmd_ready; the array is read into stage 0 at that edge.
  - Each stage advances when the next stage is empty or is itself advancing. The final stage advances on ram_rd_resp_ready.
  - ram_rd_cmd_ready[i] = stage 0 empty OR stage 0 advancing. Bubbles collapse, so full throughput is one read per cycle with ready held high.
  - Unstalled latency: response valid exactly PIPELINE cycles after acceptance.
  - ram_rd_resp_valid/data come from the last stage. Data is held stable while valid & !ready.
  - Responses are in order per segment. No accepted read is dropped or duplicated.
- Read and write to the same address in the same cycle: read returns the old data (read-first).
- Address wrap: none. Addresses are exactly SEG_ADDR_WIDTH bits.
- Reset mid-operation: all in-flight reads are discarded (valid cleared). A write accepted at the edge where reset asserts is undefined.

Decomposition:
- Shared package dma_ram_pkg:
  - segment width constants
  - a helper function for the byte-enable merge
- One natural sub-module: dma_seg_ram_segment (single-segment array, write port and read pipeline), instantiated SEG_COUNT times in a generate loop.
- Top level is slicing only.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 5 cycles.
  - Expect: all ready=0, ram_rd_resp_valid=0, ram_wr_done=0.
  - After release: ram_wr_cmd_ready=4'hF.
- Write/read round trip:
  - Stimulus: seg0 writes addr 0x010, be=16'hFFFF, data=128'h00112233_44556677_8899AABB_CCDDEEFF; ram_wr_done[0] is checked next cycle. Then read addr 0x010 with resp_ready=1.
  - Expect: resp_valid[0] exactly 2 cycles after accept, with the written data.
- Partial byte enable:
  - Stimulus: seg2 writes addr 0x020, all 0xAA. Then write addr 0x020 with be=16'h000F, data all 0x55.
  - Expect: read returns upper 12 bytes 0xAA and lower 4 bytes 0x55.
- Backpressure:
  - Stimulus: issue 4 consecutive reads (addrs 0 to 3) on seg1 with resp_ready=0.
  - Expect: cmd_ready drops after PIPELINE accepts. Once resp_ready=1, all 4 responses come out in order, no loss, data held while stalled.
- Segment independence:
  - Stimulus: on the same cycle, seg0 writes addr 5 and seg3 reads addr 5 (previously 0x…77).
  - Expect: seg3 returns 0x…77. seg0 addr 5 holds the new value on a later read.
- Read-during-write collision:
  - Stimulus: write and read addr 0x100 on seg1 in the same cycle (old value 1, new value 2).
  - Expect: the response is 1; a subsequent read returns 2.
